imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory: receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to the instruction memory's write port at consecutive word addresses starting at 0.
- Holds the CPU (cpu_hold) while loading, so programs can be loaded at run time instead of from initial blocks.
- Sits between a byte source (UART RX or testbench) and the instruction memory write port.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: the byte source / memory side. slave: the loader itself.
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to consecutive word addresses from 0 and holds
// the CPU while a load is in progress.
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_idx;
  logic [DATA_W-1:0] asm_word;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   eff_len;
  logic [ADDR_W:0]   count_inc;
  logic              start_ok;
  logic              byte_acc;
  logic              byte_ready_d;
  logic              mem_we_d;

  // The assembly register is the write data; it is only ever read in WRITE,
  // after all four byte lanes have been refreshed.
  assign bus.mem_wdata  = asm_word;
  assign bus.mem_addr   = addr_q;
  assign bus.byte_ready = byte_ready_d;
  assign bus.mem_we     = mem_we_d;
  assign count_inc      = word_count + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update together from pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode; outputs depend on registered state only,
  // inputs only steer the next state and the datapath enables.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would infer a latch.
    state_nxt    = state;
    byte_ready_d = 1'b0;
    mem_we_d     = 1'b0;
    cpu_hold     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    start_ok     = 1'b0;
    byte_acc     = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        // Abort wins over a simultaneous start even though it has no other
        // effect here.
        if (start && !abort) begin
          start_ok  = 1'b1;
          state_nxt = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        byte_ready_d = 1'b1;
        cpu_hold     = 1'b1;
        busy         = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (bus.byte_valid) begin
          byte_acc = 1'b1;
          if (byte_idx == 2'd3) state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // The word is complete, so the write goes out even if abort is high.
        mem_we_d = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (abort)                     state_nxt = S_IDLE;
        else if (count_inc == eff_len) state_nxt = S_DONE;
        else                           state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: length latch, byte assembly, word address and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_len    <= '0;
      word_count <= '0;
      addr_q     <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
    end else begin
      if (start_ok) begin
        eff_len    <= (len > MAX_LEN) ? MAX_LEN : len;
        word_count <= '0;
        addr_q     <= '0;
        byte_idx   <= '0;
      end
      if (byte_acc) begin
        asm_word[8*byte_idx +: 8] <= bus.byte_data;
        byte_idx                  <= byte_idx + 2'd1;
      end
      if (busy && abort) begin
        byte_idx <= '0;
      end
      // Address wraps naturally at 2**ADDR_W.
      if (state == S_WRITE && !abort) begin
        word_count <= count_inc;
        addr_q     <= addr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives bytes through the interface,
// logs every memory write and compares against hand-computed values.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W = 6;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [ADDR_W:0] len   = '0;
  logic            cpu_hold;
  logic            busy;
  logic            done;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .bus        (bus.slave),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Write log filled on the falling edge, away from the active edge.
  logic [ADDR_W-1:0] log_addr [0:511];
  logic [31:0]       log_data [0:511];
  int                wr_total       = 0;
  int                ready_in_write = 0;

  // Record every memory write and flag any byte_ready seen alongside it.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we === 1'b1) begin
      if (wr_total < 512) begin
        log_addr[wr_total] <= bus.mem_addr;
        log_data[wr_total] <= bus.mem_wdata;
      end
      wr_total <= wr_total + 1;
      if (bus.byte_ready !== 1'b0) ready_in_write <= ready_in_write + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) step();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("byte_ready", {31'd0, bus.byte_ready}, 32'd1);
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], int'($urandom_range(gapmax, 0)));
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = (ADDR_W+1)'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("done", {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, bus.mem_we},     32'd0);
    check({tag, "_addr"},  {26'd0, bus.mem_addr},   32'd0);
    check({tag, "_wdata"}, bus.mem_wdata,           32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold},       32'd0);
    check({tag, "_busy"},  {31'd0, busy},           32'd0);
    check({tag, "_done"},  {31'd0, done},           32'd0);
    check({tag, "_count"}, {25'd0, word_count},     32'd0);
  endtask

  initial begin
    int base;
    int bad;
    logic [7:0]  i8;
    logic [31:0] exp_w;

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state.
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Two-word load with byte_valid effectively held high.
    base = wr_total;
    do_start(2);
    check("two_hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("two_busy_after_start", {31'd0, busy}, 32'd1);
    send_word(32'h001F8F93, 0);
    check("two_hold_mid", {31'd0, cpu_hold}, 32'd1);
    send_word(32'h00000083, 0);
    wait_done();
    check("two_nwrites", wr_total - base, 32'd2);
    check("two_w0_data", log_data[base],   32'h001F8F93);
    check("two_w0_addr", {26'd0, log_addr[base]},   32'd0);
    check("two_w1_data", log_data[base+1], 32'h00000083);
    check("two_w1_addr", {26'd0, log_addr[base+1]}, 32'd1);
    check("two_count",   {25'd0, word_count}, 32'd2);
    check("two_hold_done", {31'd0, cpu_hold}, 32'd0);
    check("two_busy_done", {31'd0, busy}, 32'd0);

    // Gaps between bytes, single word.
    base = wr_total;
    do_start(1);
    send_word(32'h00000013, 3);
    wait_done();
    check("gap_nwrites", wr_total - base, 32'd1);
    check("gap_data", log_data[base], 32'h00000013);
    check("gap_addr", {26'd0, log_addr[base]}, 32'd0);
    check("gap_count", {25'd0, word_count}, 32'd1);

    // len = 0 completes at once with no writes.
    base = wr_total;
    do_start(0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd0);
    step();
    check("len0_nwrites", wr_total - base, 32'd0);
    check("len0_count", {25'd0, word_count}, 32'd0);

    // len = 100 clamps to 64 words covering every address.
    base = wr_total;
    do_start(100);
    for (int i = 0; i < 64; i++) begin
      i8 = 8'(i);
      send_word({8'h5A, ~i8, 8'hA5, i8}, 0);
    end
    wait_done();
    check("clamp_nwrites", wr_total - base, 32'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      i8    = 8'(i);
      exp_w = {8'h5A, ~i8, 8'hA5, i8};
      if (log_data[base+i] !== exp_w || log_addr[base+i] !== 6'(i)) bad++;
    end
    check("clamp_words_bad", bad, 32'd0);
    check("clamp_last", log_data[base+63], 32'h5AC0A53F);
    check("clamp_count", {25'd0, word_count}, 32'd64);
    check("clamp_addr_wrap", {26'd0, bus.mem_addr}, 32'd0);

    // Start while busy is ignored.
    base = wr_total;
    do_start(2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start = 1'b1;
    len   = (ADDR_W+1)'(3);
    step();
    start = 1'b0;
    check("busy_start_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'hCAFEF00D, 0);
    wait_done();
    check("busy_start_nwrites", wr_total - base, 32'd2);
    check("busy_start_w0", log_data[base], 32'h44332211);
    check("busy_start_w1", log_data[base+1], 32'hCAFEF00D);
    check("busy_start_count", {25'd0, word_count}, 32'd2);

    // Abort after two bytes of word 1.
    base = wr_total;
    do_start(3);
    send_word(32'h12345678, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hold", {31'd0, cpu_hold}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_count", {25'd0, word_count}, 32'd1);
    step();
    check("abort_nwrites", wr_total - base, 32'd1);
    check("abort_w0", log_data[base], 32'h12345678);
    base = wr_total;
    do_start(1);
    send_word(32'h0000A0B7, 0);
    wait_done();
    check("abort_reload_n", wr_total - base, 32'd1);
    check("abort_reload_addr", {26'd0, log_addr[base]}, 32'd0);
    check("abort_reload_data", log_data[base], 32'h0000A0B7);

    // Asynchronous reset during LOAD.
    base = wr_total;
    do_start(2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h03;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step();
    step();
    bus.byte_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("rst_mid_nwrites", wr_total - base, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    do_start(1);
    send_word(32'hDEADBEEF, 0);
    wait_done();
    check("rst_reload_n", wr_total - base, 32'd1);
    check("rst_reload_data", log_data[base], 32'hDEADBEEF);
    check("rst_reload_addr", {26'd0, log_addr[base]}, 32'd0);

    // No byte was ever offered a ready while a write was in flight.
    check("ready_in_write", ready_in_write, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
